hex_segment_word_assembler: RTL and testbench

- Reverse path of the nibble-to-7-segment decoder.
- Accepts a stream of active-low 7-segment patterns over a valid/ready handshake and decodes each back to a hex nibble.
- Packs DIGITS nibbles, most-significant first, into one word for the 16-bit processor datapath.
- Rejects illegal patterns with a sticky error flag and a saturating error counter.

---
 rtl/hex_segment_word_assembler.sv | 140 ++++++++++++++
 tb/tb_hex_segment_word_assembler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hex_segment_word_assembler.sv
// Decodes active-low 7-segment patterns back to hex nibbles and packs DIGITS of them, MSB first, into one word.
// Optional feature: define SEG_BLANK_SKIP_EN to accept the all-off (blank) pattern as a no-op digit.
module hex_segment_word_assembler #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic [0:6]             SegIn,
  input  logic                   SegValid,
  output logic                   SegReady,
  output logic [4*DIGITS-1:0]    Word,
  output logic                   WordValid,
  input  logic                   WordReady,
  input  logic                   ClearErr,
  output logic                   ErrFlag,
  output logic [ERR_CNT_W-1:0]   ErrCount
);

  localparam int unsigned WORD_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e               state_q, state_d;
  logic [WORD_W-1:0]    asm_q, asm_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [3:0]           nib_c;
  logic                 legal_c;
  logic                 blank_c;
  logic                 accept_c;

  // Inverse of the display encoding; patterns are listed segment a..g, 0 = lit.
  always_comb begin
    nib_c   = 4'h0;
    legal_c = 1'b1;
    case (SegIn)
      7'b0000001: nib_c = 4'h0;
      7'b1001111: nib_c = 4'h1;
      7'b0010010: nib_c = 4'h2;
      7'b0000110: nib_c = 4'h3;
      7'b1001100: nib_c = 4'h4;
      7'b0100100: nib_c = 4'h5;
      7'b0100000: nib_c = 4'h6;
      7'b0001101: nib_c = 4'h7;
      7'b0000000: nib_c = 4'h8;
      7'b0000100: nib_c = 4'h9;
      7'b0001000: nib_c = 4'hA;
      7'b1100000: nib_c = 4'hB;
      7'b0110001: nib_c = 4'hC;
      7'b1000010: nib_c = 4'hD;
      7'b0110000: nib_c = 4'hE;
      7'b0111000: nib_c = 4'hF;
      default:    legal_c = 1'b0;
    endcase
  end

`ifdef SEG_BLANK_SKIP_EN
  assign blank_c = (SegIn == 7'b1111111);
`else
  assign blank_c = 1'b0;
`endif

  assign accept_c = SegValid && (state_q == COLLECT);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= COLLECT;
      asm_q      <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      asm_q      <= asm_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Next-state: collect digits, hold the finished word, track illegal patterns.
  always_comb begin
    state_d    = state_q;
    asm_d      = asm_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      COLLECT: begin
        if (accept_c && !blank_c) begin
          if (legal_c) begin
            asm_d = WORD_W'({asm_q, nib_c});
            if (cnt_q == CNT_W'(DIGITS - 1)) begin
              cnt_d   = '0;
              word_d  = WORD_W'({asm_q, nib_c});
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            asm_d      = '0;
            cnt_d      = '0;
            err_flag_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
          end
        end
      end
      HOLD: begin
        if (WordReady) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Clear takes priority over an error arriving in the same cycle.
    if (ClearErr) begin
      err_flag_d = 1'b0;
      err_cnt_d  = '0;
    end
  end

  assign SegReady  = (state_q == COLLECT);
  assign WordValid = (state_q == HOLD);
  assign Word      = word_q;
  assign ErrFlag   = err_flag_q;
  assign ErrCount  = err_cnt_q;

endmodule

// File: tb/tb_hex_segment_word_assembler.sv
// Directed bench for hex_segment_word_assembler (DIGITS=4, ERR_CNT_W=8); honours SEG_BLANK_SKIP_EN if defined.
module tb_hex_segment_word_assembler;

  logic        Clock;
  logic        Resetn;
  logic [0:6]  SegIn;
  logic        SegValid;
  logic        SegReady;
  logic [15:0] Word;
  logic        WordValid;
  logic        WordReady;
  logic        ClearErr;
  logic        ErrFlag;
  logic [7:0]  ErrCount;

  int unsigned n_checks;
  int unsigned n_errors;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100, SA = 7'b0001000, SB = 7'b1100000, SC = 7'b0110001;
  localparam logic [6:0] SD = 7'b1000010, SE = 7'b0110000, SF = 7'b0111000;
  localparam logic [6:0] SBAD = 7'b1111110, SBLANK = 7'b1111111;

  hex_segment_word_assembler #(.DIGITS(4), .ERR_CNT_W(8)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .SegIn     (SegIn),
    .SegValid  (SegValid),
    .SegReady  (SegReady),
    .Word      (Word),
    .WordValid (WordValid),
    .WordReady (WordReady),
    .ClearErr  (ClearErr),
    .ErrFlag   (ErrFlag),
    .ErrCount  (ErrCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one digit for exactly one rising edge; returns at edge+1.
  task automatic send(input logic [6:0] seg);
    SegIn    = seg;
    SegValid = 1'b1;
    @(posedge Clock);
    #1;
    SegValid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic release_word();
    WordReady = 1'b1;
    @(posedge Clock);
    #1;
    WordReady = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    Resetn    = 1'b0;
    SegIn     = 7'b0;
    SegValid  = 1'b0;
    WordReady = 1'b0;
    ClearErr  = 1'b0;
    #22;
    Resetn = 1'b1;
    #1;
    check("rst_word", 32'(Word), 32'h0);
    check("rst_wvalid", 32'(WordValid), 32'h0);
    check("rst_segready", 32'(SegReady), 32'h1);
    check("rst_errflag", 32'(ErrFlag), 32'h0);
    check("rst_errcount", 32'(ErrCount), 32'h0);
    @(posedge Clock);
    #1;

    // Basic word 0x1234
    send(S1); send(S2); send(S3);
    check("w1234_pre_valid", 32'(WordValid), 32'h0);
    send(S4);
    check("w1234_valid", 32'(WordValid), 32'h1);
    check("w1234_word", 32'(Word), 32'h1234);
    check("w1234_segready", 32'(SegReady), 32'h0);

    // Hold with SegIn driven (ignored), then release
    SegIn    = S0;
    SegValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("hold_word", 32'(Word), 32'h1234);
      check("hold_valid", 32'(WordValid), 32'h1);
    end
    SegValid = 1'b0;
    release_word();
    check("rel_valid", 32'(WordValid), 32'h0);
    check("rel_segready", 32'(SegReady), 32'h1);
    check("rel_word_kept", 32'(Word), 32'h1234);

    send(SA); send(SB); send(SC); send(SD);
    check("wABCD_word", 32'(Word), 32'hABCD);
    check("wABCD_valid", 32'(WordValid), 32'h1);
    release_word();

    // Illegal pattern discards partial word
    send(S0); send(S0); send(SBAD);
    check("bad_errflag", 32'(ErrFlag), 32'h1);
    check("bad_errcount", 32'(ErrCount), 32'h1);
    check("bad_word_kept", 32'(Word), 32'hABCD);
    send(SF); send(SF); send(SF);
    check("ffff_pre_valid", 32'(WordValid), 32'h0);
    send(SF);
    check("ffff_word", 32'(Word), 32'hFFFF);
    check("ffff_valid", 32'(WordValid), 32'h1);
    release_word();

    // Saturation: 1 + 259 errors caps at 255
    for (int i = 0; i < 259; i++) send(SBAD);
    check("sat_errcount", 32'(ErrCount), 32'hFF);
    check("sat_errflag", 32'(ErrFlag), 32'h1);
    ClearErr = 1'b1;
    idle(1);
    ClearErr = 1'b0;
    check("clr_errflag", 32'(ErrFlag), 32'h0);
    check("clr_errcount", 32'(ErrCount), 32'h0);

    // Clear wins over a simultaneous illegal digit
    send(SBAD);
    check("pre_clrwin_count", 32'(ErrCount), 32'h1);
    ClearErr = 1'b1;
    send(SBAD);
    ClearErr = 1'b0;
    check("clrwin_errflag", 32'(ErrFlag), 32'h0);
    check("clrwin_errcount", 32'(ErrCount), 32'h0);

    // Asynchronous reset mid-word
    send(SBAD);
    send(S1); send(S2);
    #2;
    Resetn = 1'b0;
    #1;
    check("arst_word", 32'(Word), 32'h0);
    check("arst_valid", 32'(WordValid), 32'h0);
    check("arst_segready", 32'(SegReady), 32'h1);
    check("arst_errflag", 32'(ErrFlag), 32'h0);
    check("arst_errcount", 32'(ErrCount), 32'h0);
    #2;
    Resetn = 1'b1;
    @(posedge Clock);
    #1;

    // WordReady outside HOLD has no effect
    WordReady = 1'b1;
    send(S6);
    WordReady = 1'b0;
    send(S8); send(S9); send(SE);
    check("w689E_word", 32'(Word), 32'h689E);
    check("w689E_valid", 32'(WordValid), 32'h1);
    release_word();

    // Blank digit handling
    send(SBLANK); send(S1); send(SBLANK); send(S2); send(S3); send(S4);
`ifdef SEG_BLANK_SKIP_EN
    check("blank_word", 32'(Word), 32'h1234);
    check("blank_valid", 32'(WordValid), 32'h1);
    check("blank_errcount", 32'(ErrCount), 32'h0);
    release_word();
`else
    check("blank_errcount", 32'(ErrCount), 32'h2);
    check("blank_valid", 32'(WordValid), 32'h0);
    check("blank_word_kept", 32'(Word), 32'h689E);
    send(S5);
    check("blank_word", 32'(Word), 32'h2345);
    check("blank_final_valid", 32'(WordValid), 32'h1);
    release_word();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
